// File: rtl/mont_seq_pkg.sv
// Shared types and helpers for the word-serial Montgomery control sequencer.
//   state_t   : sequencer FSM states
//   phase_t   : phase tag presented to the multiply/accumulate/reduce datapath
//   idx_width : index width for a given operand width
package mont_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC  = 3'd1,
    RED  = 3'd2,
    SUB  = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PH_NONE = 2'd0,
    PH_ACC  = 2'd1,
    PH_RED  = 2'd2,
    PH_SUB  = 2'd3
  } phase_t;

  // Width of the word indices; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/mont_idx_counter.sv
// Word index counter that wraps to zero by equality with a limit.
//   clk, rst_n : clock, async active-low reset
//   ce         : clock enable, counter holds when low
//   clr        : synchronous clear (priority over inc)
//   inc        : advance by one, or wrap to 0 when cnt == limit
//   limit      : last valid count value
//   cnt        : current count (registered)
//   wrap       : combinational, inc && cnt == limit
module mont_idx_counter #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap = inc && (cnt_q == limit);
  assign cnt  = cnt_q;

  // Next count: clear wins, wrap is by compare-equal, never by overflow.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ce) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mont_word_sequencer.sv
// Control sequencer for word-serial Montgomery multiplication.
// Walks outer index i and inner index j through ACC/RED passes for every i,
// then one final SUB pass, and signals completion with a one-cycle done.
//   clk, rst_n   : clock, async active-low reset
//   ce           : clock enable, all state and outputs hold when low
//   start        : start request, accepted only in IDLE
//   t_sub_1      : word count minus one, latched on start
//   abort        : (only with MONT_SEQ_ABORT_EN) return to IDLE without done
//   busy, done   : handshake to the exponentiation controller
//   step_valid   : one datapath word-step this cycle
//   phase        : 0 none, 1 ACC, 2 RED, 3 SUB
//   i_idx, j_idx : outer / inner word index
//   first_j      : step with j_idx == 0
//   last_j       : step with j_idx == t_lat
// Optional feature macro: MONT_SEQ_ABORT_EN.
module mont_word_sequencer
  import mont_seq_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 1025,
  localparam int unsigned IW         = idx_width(DATA_WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          start,
  input  logic [IW-1:0] t_sub_1,
`ifdef MONT_SEQ_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  output logic          done,
  output logic          step_valid,
  output logic [1:0]    phase,
  output logic [IW-1:0] i_idx,
  output logic [IW-1:0] j_idx,
  output logic          first_j,
  output logic          last_j
);

  state_t        state_q, state_d;
  logic [IW-1:0] t_lat_q, t_lat_d;
  logic          i_clr, j_clr, i_inc, j_inc, i_wrap, j_wrap;
  logic [IW-1:0] j_nxt;

  logic   busy_q, busy_d, done_q, done_d, sv_q, sv_d;
  logic   first_q, first_d, last_q, last_d;
  phase_t phase_q, phase_d;

  logic abort_req;
`ifdef MONT_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // j advances on every step cycle; i advances when a RED pass completes.
  assign j_inc = (state_q == ACC) || (state_q == RED) || (state_q == SUB);
  assign i_inc = (state_q == RED) && j_wrap;

  mont_idx_counter #(.W(IW)) u_i_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .clr   (i_clr),
    .inc   (i_inc),
    .limit (t_lat_q),
    .cnt   (i_idx),
    .wrap  (i_wrap)
  );

  mont_idx_counter #(.W(IW)) u_j_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .clr   (j_clr),
    .inc   (j_inc),
    .limit (t_lat_q),
    .cnt   (j_idx),
    .wrap  (j_wrap)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    t_lat_d = t_lat_q;
    i_clr   = 1'b0;
    j_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          t_lat_d = t_sub_1;
          i_clr   = 1'b1;
          j_clr   = 1'b1;
          state_d = ACC;
        end
      end
      ACC:  if (j_wrap) state_d = RED;
      RED:  if (j_wrap) state_d = i_wrap ? SUB : ACC;
      SUB:  if (j_wrap) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides everything outside IDLE, including a concurrent start.
    if (abort_req && (state_q != IDLE)) begin
      state_d = IDLE;
      i_clr   = 1'b1;
      j_clr   = 1'b1;
    end
  end

  // Mirror of the j counter's next value, used to register first_j/last_j.
  always_comb begin
    j_nxt = j_idx;
    if (j_clr) begin
      j_nxt = '0;
    end else if (j_inc) begin
      j_nxt = j_wrap ? '0 : j_idx + IW'(1);
    end
  end

  // Output decode from the next state so every output is a flop.
  always_comb begin
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    sv_d    = (state_d == ACC) || (state_d == RED) || (state_d == SUB);
    phase_d = PH_NONE;
    case (state_d)
      ACC:     phase_d = PH_ACC;
      RED:     phase_d = PH_RED;
      SUB:     phase_d = PH_SUB;
      default: phase_d = PH_NONE;
    endcase
    first_d = sv_d && (j_nxt == '0);
    last_d  = sv_d && (j_nxt == t_lat_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_lat_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sv_q    <= 1'b0;
      phase_q <= PH_NONE;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      t_lat_q <= t_lat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sv_q    <= sv_d;
      phase_q <= phase_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign step_valid = sv_q;
  assign phase      = phase_q;
  assign first_j    = first_q;
  assign last_j     = last_q;

endmodule

// File: tb/tb_mont_word_sequencer.sv
// Self-checking bench for mont_word_sequencer. Expected per-cycle outputs come
// from a nested-loop model of the (phase, i, j) walk for a given word count.
module tb_mont_word_sequencer;

  localparam int unsigned IW = 11;
  localparam int unsigned VW = 5 + 2 * IW + 2;

  logic          clk, rst_n, ce, start;
  logic [IW-1:0] t_sub_1;
`ifdef MONT_SEQ_ABORT_EN
  logic          abort;
`endif
  logic          busy, done, step_valid, first_j, last_j;
  logic [1:0]    phase;
  logic [IW-1:0] i_idx, j_idx;

  mont_word_sequencer #(.DATA_WIDTH(1025)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .start      (start),
    .t_sub_1    (t_sub_1),
`ifdef MONT_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .done       (done),
    .step_valid (step_valid),
    .phase      (phase),
    .i_idx      (i_idx),
    .j_idx      (j_idx),
    .first_j    (first_j),
    .last_j     (last_j)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [VW-1:0] act_vec = {busy, done, step_valid, phase, i_idx, j_idx, first_j, last_j};

  typedef struct {
    logic [1:0] ph;
    int         i;
    int         j;
    bit         dn;
  } ent_t;

  typedef struct {
    int tsub;
    int mode;   // 0: ce always 1, 1: ce alternating, 2: ce random
    int exp_n;  // expected number of step_valid cycles
  } vec_t;

  ent_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference walk: for each i an ACC pass then a RED pass over j, then SUB, then DONE.
  task automatic build(input int t);
    exp_q.delete();
    for (int i = 0; i < t; i++) begin
      for (int j = 0; j < t; j++) exp_q.push_back('{2'd1, i, j, 1'b0});
      for (int j = 0; j < t; j++) exp_q.push_back('{2'd2, i, j, 1'b0});
    end
    for (int j = 0; j < t; j++) exp_q.push_back('{2'd3, 0, j, 1'b0});
    exp_q.push_back('{2'd0, 0, 0, 1'b1});
  endtask

  function automatic logic [VW-1:0] exp_vec(input ent_t e, input int t_lat);
    logic sv;
    sv = (e.ph != 2'd0);
    return {1'b1, e.dn, sv, e.ph, IW'(e.i), IW'(e.j), sv && (e.j == 0), sv && (e.j == t_lat)};
  endfunction

  // Start an operation and follow it cycle by cycle; stop_idx >= 0 returns early
  // with the DUT showing model entry stop_idx.
  task automatic run_op(input int tsub, input int mode, input bit hold, input int stop_idx,
                        input int exp_n, input string name);
    int idx, steps, guard, sz;
    bit ce_nx;
    idx = 0; steps = 0; guard = 0;
    build(tsub + 1);
    sz      = exp_q.size();
    start   = 1'b1;
    t_sub_1 = IW'(tsub);
    ce      = 1'b1;
    tick;
    if (!hold) start = 1'b0;
    while (idx < sz && guard < 4000) begin
      if (idx == stop_idx) return;
      check_vec(name, act_vec, exp_vec(exp_q[idx], tsub));
      if (hold && guard == 3) t_sub_1 = IW'(3);
      case (mode)
        0:       ce_nx = 1'b1;
        1:       ce_nx = ~ce;
        default: ce_nx = ($urandom_range(0, 3) != 0);
      endcase
      ce = ce_nx;
      tick;
      if (ce_nx) begin
        if (exp_q[idx].ph != 2'd0) steps++;
        idx++;
      end
      guard++;
    end
    if (idx < sz) begin
      failures++;
      $display("FAIL %s_timeout: reached entry %0d of %0d", name, idx, sz);
    end
    ce = 1'b1;
    check_vec({name, "_idle"}, act_vec, '0);
    check_int({name, "_steps"}, steps, exp_n);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{0, 0, 3};
    tbl[1] = '{2, 0, 21};
    tbl[2] = '{1, 1, 10};
    tbl[3] = '{3, 0, 36};
    tbl[4] = '{5, 0, 78};
    tbl[5] = '{0, 1, 3};

    rst_n   = 1'b0;
    ce      = 1'b1;
    start   = 1'b0;
    t_sub_1 = '0;
`ifdef MONT_SEQ_ABORT_EN
    abort   = 1'b0;
`endif
    #2;
    check_vec("reset", act_vec, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    check_vec("post_reset_idle", act_vec, '0);

    // start with ce low must not be accepted
    ce = 1'b0; start = 1'b1; t_sub_1 = IW'(2);
    tick;
    tick;
    check_vec("ce_low_idle", act_vec, '0);
    start = 1'b0; ce = 1'b1;
    tick;

    foreach (tbl[k]) run_op(tbl[k].tsub, tbl[k].mode, 1'b0, -1, tbl[k].exp_n, $sformatf("tbl%0d", k));

    // start held through busy, t_sub_1 changed mid-run: no restart, t_lat stays 1
    run_op(1, 0, 1'b1, -1, 10, "hold_start");
    // the still-high start is taken only now, with the new word count
    run_op(3, 0, 1'b0, -1, 36, "after_hold");

    // asynchronous reset at the first RED step with i=1
    run_op(3, 0, 1'b0, 12, 36, "pre_reset");
    check_vec("at_red_i1", act_vec, {1'b1, 1'b0, 1'b1, 2'd2, IW'(1), IW'(0), 1'b1, 1'b0});
    rst_n = 1'b0;
    #1;
    check_vec("async_reset", act_vec, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    check_vec("reset_no_done", act_vec, '0);
    run_op(3, 0, 1'b0, -1, 36, "after_reset");

`ifdef MONT_SEQ_ABORT_EN
    // abort at the 5th ACC step, asserted together with start
    run_op(3, 0, 1'b0, 8, 36, "pre_abort");
    abort = 1'b1; start = 1'b1;
    tick;
    check_vec("abort_idle", act_vec, '0);
    abort = 1'b0; start = 1'b0;
    tick;
    check_vec("abort_no_done", act_vec, '0);
    run_op(2, 0, 1'b0, -1, 21, "after_abort");
`endif

    for (int r = 0; r < 6; r++) begin
      int ts;
      ts = $urandom_range(0, 5);
      run_op(ts, 2, 1'b0, -1, 2 * (ts + 1) * (ts + 1) + (ts + 1), $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
